// File: rtl/sm_rom_pkg.sv
// Shared types, defaults and the address legality check for the ROM arbiter.
package sm_rom_pkg;

    localparam int unsigned DEF_SIZE         = 64;
    localparam int unsigned DEF_STARVE_LIMIT = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DP   = 2'd2
    } owner_e;

    // An access is an error when it is not word aligned or lands past the last word.
    function automatic logic addr_err(input logic [31:0] addr, input logic [31:0] size_words);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= size_words);
    endfunction

endpackage

// File: rtl/sm_rom_arb_if.sv
// Fetch port, data port and ROM-side signals of the two-port ROM arbiter.
interface sm_rom_arb_if;

    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        if_err;

    logic        dp_req;
    logic [31:0] dp_addr;
    logic        dp_gnt;
    logic        dp_rvalid;
    logic [31:0] dp_rdata;
    logic        dp_err;

    logic [31:0] rom_a;
    logic [31:0] rom_rd;

    modport slave (
        input  if_req, if_addr, dp_req, dp_addr, rom_rd,
        output if_gnt, if_rvalid, if_rdata, if_err,
        output dp_gnt, dp_rvalid, dp_rdata, dp_err,
        output rom_a
    );

    modport master (
        output if_req, if_addr, dp_req, dp_addr, rom_rd,
        input  if_gnt, if_rvalid, if_rdata, if_err,
        input  dp_gnt, dp_rvalid, dp_rdata, dp_err,
        input  rom_a
    );

endinterface

// File: rtl/sm_rom_arb_pick.sv
// Combinational arbitration: fetch has priority unless the data port is starved.
module sm_rom_arb_pick (
    input  logic if_req,
    input  logic dp_req,
    input  logic starved,
    output logic if_win,
    output logic dp_win
);

    always_comb begin
        dp_win = dp_req && (starved || !if_req);
        if_win = if_req && !dp_win;
    end

endmodule

// File: rtl/sm_rom_arb.sv
// Two-port ROM arbiter: one ROM access per cycle, single-cycle registered responses.
//
// state    | meaning
// OWN_NONE | no access last cycle, no response this cycle
// OWN_IF   | fetch port was granted last cycle, its response is valid now
// OWN_DP   | data port was granted last cycle, its response is valid now
module sm_rom_arb
    import sm_rom_pkg::*;
#(
    parameter int unsigned SIZE         = DEF_SIZE,
    parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic         clk,
    input  logic         rst,
    sm_rom_arb_if.slave  bus
);

    logic [3:0]  starve_cnt;
    logic        starved;
    logic        if_win;
    logic        dp_win;
    logic        if_gnt;
    logic        dp_gnt;
    owner_e      owner_q;
    owner_e      owner_d;
    logic [31:0] if_rdata_q;
    logic [31:0] dp_rdata_q;
    logic        if_err_q;
    logic        dp_err_q;
    logic        if_bad;
    logic        dp_bad;

    assign starved = bus.dp_req && (starve_cnt == 4'(STARVE_LIMIT));

    sm_rom_arb_pick u_pick (
        .if_req  (bus.if_req),
        .dp_req  (bus.dp_req),
        .starved (starved),
        .if_win  (if_win),
        .dp_win  (dp_win)
    );

    // Grants are suppressed during reset so nothing issued then can produce a response.
    assign if_gnt = if_win && !rst;
    assign dp_gnt = dp_win && !rst;
    assign if_bad = addr_err(bus.if_addr, 32'(SIZE));
    assign dp_bad = addr_err(bus.dp_addr, 32'(SIZE));

    always_comb begin
        bus.rom_a = 32'd0;
        if (if_gnt) begin
            bus.rom_a = {2'b00, bus.if_addr[31:2]};
        end else if (dp_gnt) begin
            bus.rom_a = {2'b00, bus.dp_addr[31:2]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q <= OWN_NONE;
        end else begin
            owner_q <= owner_d;
        end
    end

    always_comb begin
        owner_d       = OWN_NONE;
        bus.if_gnt    = if_gnt;
        bus.dp_gnt    = dp_gnt;
        bus.if_rvalid = (owner_q == OWN_IF);
        bus.dp_rvalid = (owner_q == OWN_DP);
        bus.if_rdata  = if_rdata_q;
        bus.if_err    = if_err_q;
        bus.dp_rdata  = dp_rdata_q;
        bus.dp_err    = dp_err_q;
        if (if_gnt) begin
            owner_d = OWN_IF;
        end else if (dp_gnt) begin
            owner_d = OWN_DP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= 4'd0;
        end else if (bus.dp_req && !dp_gnt) begin
            starve_cnt <= starve_cnt + 4'd1;
        end else begin
            starve_cnt <= 4'd0;
        end
    end

    // Each port's response registers update only on its own grant and hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            if_rdata_q <= 32'd0;
            if_err_q   <= 1'b0;
            dp_rdata_q <= 32'd0;
            dp_err_q   <= 1'b0;
        end else begin
            if (if_gnt) begin
                if_rdata_q <= if_bad ? 32'd0 : bus.rom_rd;
                if_err_q   <= if_bad;
            end
            if (dp_gnt) begin
                dp_rdata_q <= dp_bad ? 32'd0 : bus.rom_rd;
                dp_err_q   <= dp_bad;
            end
        end
    end

endmodule

// File: doc/sm_rom_arb.md
SM_ROM_ARB -- requirements
Module: sm_rom_arb

Interface
REQ-001 Parameter SIZE, default 64, ROM depth in 32-bit words; addresses at or above SIZE words are out of range.
REQ-002 Parameter STARVE_LIMIT, default 4, number of consecutive lost arbitration cycles after which the data port is forced to win (legal range 1..15).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 if_req  input  1  fetch port request.
REQ-006 if_addr  input  32  fetch byte address.
REQ-007 if_gnt  output  1  fetch request accepted this cycle (combinational).
REQ-008 if_rvalid  output  1  fetch response valid (registered).
REQ-009 if_rdata  output  32  fetch response data.
REQ-010 if_err  output  1  fetch response error: misaligned or out of range.
REQ-011 dp_req, dp_addr, dp_gnt, dp_rvalid, dp_rdata, dp_err  same widths, directions and meanings as the fetch port, for the data port.
REQ-012 rom_a  output  32  word index to ROM, equal to the granted address shifted right by 2.
REQ-013 rom_rd  input  32  combinational ROM read data for rom_a.

Function
REQ-014 The block shall issue at most one ROM access per cycle.
REQ-015 Requests shall be level-held: a requester keeps req and addr stable until it sees gnt high; a grant shall consume the request in that cycle.
REQ-016 Default priority: fetch wins when both if_req and dp_req are high.
REQ-017 A 4-bit starve counter shall increment each cycle in which dp_req is high and dp_gnt is low, and clear on any dp_gnt or when dp_req is low.
REQ-018 When the starve counter equals STARVE_LIMIT and dp_req is high, the data port shall win and if_gnt shall be low.
REQ-019 When neither port requests, rom_a shall be 0 and both gnt outputs low.
REQ-020 Response latency is exactly 1 cycle: rvalid rises on the cycle after the grant, for one cycle only, on the granted port only.
REQ-021 rdata shall be the registered value of rom_rd when the access is legal; it shall be 0 when the access is an error.
REQ-022 err shall be asserted with rvalid when addr[1:0] is nonzero, or when addr[31:2] is at least SIZE; the ROM is still driven, but its data is discarded.
REQ-023 A registered grant-owner state (NONE, IF, DP) shall route the response.
  - NONE to IF on if_gnt; NONE to DP on dp_gnt.
  - IF or DP to the next owner, or to NONE, every cycle.
REQ-024 Back-to-back grants to the same port shall give rvalid on consecutive cycles (full throughput).
REQ-025 rdata and err of the non-granted port shall hold their last values; only rvalid qualifies them.

Reset
REQ-026 While rst is high at a clock edge, the following shall be set: owner to NONE, starve counter to 0, all rvalid to 0, and all rdata and err to 0.
REQ-027 A grant issued in the same cycle rst is high shall produce no response; gnt outputs shall be forced low while rst is high.
REQ-028 In the first cycle after reset deassertion the block shall arbitrate normally.

Structure
REQ-029 The owner-state enum and the error-check helper shall be placed in the shared package sm_rom_pkg.
REQ-030 The SIZE and STARVE_LIMIT defaults shall be placed in the shared package sm_rom_pkg.
REQ-031 The arbitration decision (priority plus starve override) shall be the natural sub-module, sm_rom_arb_pick: purely combinational, with the starve counter kept in the parent.
REQ-032 The sm_rom instance is not contained in the block; it is connected at the top level through rom_a and rom_rd.

Verification
REQ-033 Single fetch: if_req=1 with if_addr=0x8 for 1 cycle, ROM word[2]=0xDEADBEEF -> if_gnt=1 in that cycle; next cycle if_rvalid=1, if_rdata=0xDEADBEEF, if_err=0.
REQ-034 Contention: both ports request continuously, STARVE_LIMIT=4 -> fetch is granted 4 cycles, data port granted on the 5th, and the pattern repeats; dp_gnt occurs exactly once per 5 cycles.
REQ-035 Errors: dp_addr=0x6 -> dp_err=1 and dp_rdata=0; dp_addr=0x100 with SIZE=64 -> dp_err=1 and dp_rdata=0; if_rvalid stays 0 throughout.
REQ-036 Streaming: fetch addresses 0x0, 0x4, 0x8, 0xC on consecutive cycles -> 4 consecutive if_rvalid pulses, each carrying the matching ROM word.
REQ-037 Reset mid-operation: rst=1 in the cycle of a dp grant -> no dp_rvalid follows, starve counter reads 0, and all outputs are 0 the following cycle.
REQ-038 Idle: no requests for 10 cycles -> rom_a=0, and all gnt and rvalid outputs stay 0.
